updown_counter_nbit: RTL and testbench
======================================

Name: updown_counter_nbit

Overview:
Parametrised, programmable counter. It is the next generation of the team's fixed 4-bit counter. Features:
- configurable width and terminal value
- up/down direction
- built-in prescaler
- synchronous parallel load
- wrap or saturate mode
- registered terminal-count pulse and sticky overflow flag

It serves as the general timing and event-count primitive for the FPGA designs: display scanners, timers and event tallies.

Parameters:
WIDTH, 4, bit width of count register (1..32)
MAX_VAL, 15, highest count value. Must be <= 2^WIDTH-1. Count range is 0..MAX_VAL.
RESET_VAL, 0, count value after reset. Must be <= MAX_VAL.
PRESC_DIV, 1, prescaler ratio. One count step per PRESC_DIV enabled cycles (1..65535).

Ports:
clk  input  1  sole clock, all state updates on rising edge
rst  input  1  reset. Synchronous, active-high.
en  input  1  count enable. Advances the prescaler.
up_dn  input  1  1 = count up, 0 = count down. Sampled on the step cycle.
sat_mode  input  1  1 = saturate at limits, 0 = wrap
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
ovf_clr  input  1  clears the sticky overflow flag
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered, 1 cycle)
ovf  output  1  sticky boundary-crossing flag (registered)

Behaviour:
- Design rule: one clock domain, single clock clk, synchronous active-high reset rst. No initial blocks or delays in RTL.
- Reset (rst=1 at an edge):
  - count=RESET_VAL, tc=0, ovf=0, prescaler=0.
  - rst overrides load, en and ovf_clr in the same cycle.
  - Reset mid-count discards any partial prescaler progress.
- Priority per edge: rst > load > step > hold.
- Load (load=1, rst=0):
  - count = min(load_val, MAX_VAL), i.e. values above MAX_VAL clamp to MAX_VAL.
  - Prescaler is cleared to 0 and tc=0 for that cycle.
  - No step occurs, even if a tick was due.
- Prescaler:
  - Internal counter with ceil(log2(PRESC_DIV)) bits, minimum 1 bit.
  - While en=1 it increments each cycle. At value PRESC_DIV-1 it returns to 0 and generates an internal tick.
  - With PRESC_DIV=1 a tick occurs on every cycle with en=1.
  - en=0 freezes the prescaler and count.
- Step (tick, load=0):
  - Up, count<MAX_VAL: count+1.
  - Up, count==MAX_VAL: boundary event. sat_mode=0 gives count=0; sat_mode=1 holds at MAX_VAL.
  - Down, count>0: count-1.
  - Down, count==0: boundary event. sat_mode=0 gives count=MAX_VAL; sat_mode=1 holds at 0.
- Arithmetic stays within WIDTH bits. The design must produce no intermediate carry outside the range 0..MAX_VAL.
- tc:
  - Goes high for exactly one cycle, updating on the same edge as the boundary-event count update.
  - Low in all other cycles.
  - In saturate mode, each repeated tick at the limit is a boundary event and re-asserts tc.
- ovf:
  - Set on any boundary event; stays set until ovf_clr=1.
  - Set and clear on the same edge: set wins, ovf stays 1.
  - Load does not affect ovf.
- Direction or sat_mode changes take effect on the next step. There is no pipeline latency beyond one clock edge.
- Latency: every change to count, tc and ovf appears on the edge following the causing input sample.

Test Plan:
1. Reset: WIDTH=4, RESET_VAL=3, drive rst=1 with load=1, load_val=7, en=1 -> after edge count=3, tc=0, ovf=0. Release rst, en=0 for 5 cycles -> count stays 3.
2. Up count and wrap: MAX_VAL=9, PRESC_DIV=1, up_dn=1, sat_mode=0, en=1 from 0 -> sequence 1..9 then 0. tc=1 only in the cycle count becomes 0, then ovf=1. ovf_clr=1 together with the next boundary event -> ovf remains 1.
3. Down count and saturate: MAX_VAL=9, load 2, up_dn=0, sat_mode=1 -> count 1, 0, 0, 0. tc=1 on each of the two holds at 0. ovf=1.
4. Prescaler: PRESC_DIV=4, up count from 0, en=1 for 12 cycles -> count steps every 4th cycle, ending at 3. Toggle en low for 3 cycles mid-way -> step timing shifts by exactly 3 cycles.
5. Load priority and clamp: MAX_VAL=9, load=1 with load_val=14 on the cycle a tick is due -> count=9, no step, tc=0, prescaler restarts. Next tick up with sat_mode=0 -> count 0, tc=1.
6. Reset mid-operation: PRESC_DIV=4 with prescaler at 2 and count at 5. Assert rst for one cycle -> count=RESET_VAL, ovf=0. The first step after release comes 4 enabled cycles later.

Source files
------------

// File: rtl/updown_counter_nbit.sv
// Programmable up/down counter with prescaler, synchronous load, wrap/saturate mode, tc pulse and sticky ovf.
// Latency: count, tc and ovf update on the clock edge after the causing input sample (one cycle).
// Backpressure: none; en freezes the prescaler and the count, and load takes priority over stepping.
module updown_counter_nbit #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 15,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // The prescaler needs at least one bit, even when it divides by one.
    localparam int unsigned      PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C    = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             boundary;

    // A step is due on an enabled cycle where the prescaler is at its last value.
    assign tick = en && (presc_q == PRESC_LAST);

    // Next-state logic: load beats step, step beats hold; the limits are tested
    // before any add or subtract so no value outside 0..MAX_VAL is ever formed.
    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        boundary = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (up_dn) begin
                    if (count_q == MAX_C) begin
                        boundary = 1'b1;
                        count_d  = sat_mode ? MAX_C : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        boundary = 1'b1;
                        count_d  = sat_mode ? '0 : MAX_C;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
        // tc is a one-cycle pulse; a boundary event sets ovf and wins over a clear.
        tc_d  = boundary;
        ovf_d = boundary ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // State registers with synchronous reset; reset also drops partial prescaler progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= RESET_C;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_nbit.sv
// Bench for updown_counter_nbit: two instances (prescaler 1 and 4), MAX_VAL=9, RESET_VAL=3.
// Table vectors and hand sequences for the corner cases, then random stimulus against a model.
module tb_updown_counter_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       sat_mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr = 1'b0;
    logic [3:0] cnt1, cnt4;
    logic       tc1, tc4, ovf1, ovf4;

    always #5 clk = ~clk;

    updown_counter_nbit #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .PRESC_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt1), .tc(tc1), .ovf(ovf1)
    );

    updown_counter_nbit #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .PRESC_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt4), .tc(tc4), .ovf(ovf4)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: count as an integer, prescaler as enabled cycles modulo the ratio.
    int div_tab[2] = '{1, 4};
    int m_cnt[2] = '{0, 0};
    int m_pre[2] = '{0, 0};
    int m_tc[2] = '{0, 0};
    int m_ovf[2] = '{0, 0};

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       sat;
        logic       load;
        logic [3:0] lv;
        logic       clr;
        int         ec;
        int         etc;
        int         eov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic u, input logic s,
                                input logic l, input logic [3:0] v, input logic c,
                                input int ec, input int etc, input int eov);
        vec_t t;
        t.rst = r; t.en = e; t.up = u; t.sat = s; t.load = l; t.lv = v; t.clr = c;
        t.ec = ec; t.etc = etc; t.eov = eov;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int b;
            b = 0;
            if (rst) begin
                m_cnt[i] = 3; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else begin
                if (load) begin
                    m_cnt[i] = (int'(load_val) > 9) ? 9 : int'(load_val);
                    m_pre[i] = 0;
                end else if (en) begin
                    m_pre[i] = (m_pre[i] + 1) % div_tab[i];
                    if (m_pre[i] == 0) begin
                        if (up_dn) begin
                            if (m_cnt[i] == 9) begin b = 1; if (!sat_mode) m_cnt[i] = 0; end
                            else m_cnt[i] = m_cnt[i] + 1;
                        end else begin
                            if (m_cnt[i] == 0) begin b = 1; if (!sat_mode) m_cnt[i] = 9; end
                            else m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end
                m_tc[i] = b;
                if (b == 1) m_ovf[i] = 1;
                else if (ovf_clr) m_ovf[i] = 0;
            end
        end
    endtask

    // One clock edge; the model sees the same sampled inputs, outputs are read 1 time unit later.
    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic u, input logic s,
                          input logic l, input logic [3:0] v, input logic c);
        rst = r; en = e; up_dn = u; sat_mode = s; load = l; load_val = v; ovf_clr = c;
    endtask

    initial begin
        int n;
        // Reset overrides load; then idle hold.
        tbl.push_back(mk(1, 1, 0, 0, 1, 4'd7, 0, 3, 0, 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 3, 0, 0));
        // Up count and wrap, then clear coinciding with a boundary event.
        tbl.push_back(mk(0, 0, 1, 0, 1, 4'd0, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, k, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 1));
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, k, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd0, 1, 0, 0, 0));
        // Down count into saturation at zero.
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'd2, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 1));
        // Load clamps and suppresses the due step; limits after a load.
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'd14, 0, 9, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'd9, 0, 9, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 9, 1, 1));

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].load, tbl[i].lv, tbl[i].clr);
            clk_edge();
            chk($sformatf("tbl%0d.count", i), int'(cnt1), tbl[i].ec);
            chk($sformatf("tbl%0d.tc", i), int'(tc1), tbl[i].etc);
            chk($sformatf("tbl%0d.ovf", i), int'(ovf1), tbl[i].eov);
        end

        // Prescaled instance: wrap to set ovf, then reset mid-count with prescaler at 2.
        set_in(0, 1, 1, 0, 1, 4'd9, 0);
        clk_edge();
        chk("p4.load9", int'(cnt4), 9);
        load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clk_edge();
            chk("p4.wrap.tc", int'(tc4), (k == 4) ? 1 : 0);
        end
        chk("p4.wrap.count", int'(cnt4), 0);
        chk("p4.wrap.ovf", int'(ovf4), 1);
        set_in(0, 1, 1, 0, 1, 4'd5, 0);
        clk_edge();
        load = 1'b0;
        clk_edge();
        clk_edge();
        chk("p4.mid.count", int'(cnt4), 5);
        rst = 1'b1;
        clk_edge();
        chk("p4.rst.count", int'(cnt4), 3);
        chk("p4.rst.ovf", int'(ovf4), 0);
        chk("p4.rst.tc", int'(tc4), 0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clk_edge();
            chk("p4.after_rst.count", int'(cnt4), (k == 4) ? 4 : 3);
        end

        // Prescaler timing from zero, without and with an en gap of 3 cycles.
        set_in(0, 1, 1, 0, 1, 4'd0, 0);
        clk_edge();
        load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            clk_edge();
            chk("p4.run.count", int'(cnt4), k / 4);
        end
        load = 1'b1;
        clk_edge();
        load = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            en = !(c >= 6 && c < 9);
            clk_edge();
            if (en) n++;
            chk("p4.gap.count", int'(cnt4), n / 4);
            chk("p4.gap.tc", int'(tc4), 0);
        end
        chk("p4.gap.final", int'(cnt4), 3);

        // Random stimulus against the model for both instances.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = ($urandom_range(0, 3) != 0) ^ (c >= 1500);
            sat_mode = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            ovf_clr  = ($urandom_range(0, 7) == 0);
            clk_edge();
            chk("rnd.p1.count", int'(cnt1), m_cnt[0]);
            chk("rnd.p1.tc", int'(tc1), m_tc[0]);
            chk("rnd.p1.ovf", int'(ovf1), m_ovf[0]);
            chk("rnd.p4.count", int'(cnt4), m_cnt[1]);
            chk("rnd.p4.tc", int'(tc4), m_tc[1]);
            chk("rnd.p4.ovf", int'(ovf4), m_ovf[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
